multi_cycle_control: RTL and testbench

Main controller that sequences the multi-cycle RISC-V datapath (shared instruction/data memory, IR, OldPC, A/B, ALUOut and Data registers). A Moore FSM steps each RV32I subset instruction (lw, sw, R-type, I-type ALU, beq, jal) through fetch, decode, execute, memory and writeback cycles. It drives every datapath mux select and write enable, including the ALU control code through an ALU decoder. It is instantiated in the multi-cycle top beside the datapath.

---
 rtl/riscv_ctrl_pkg.sv | 55 +++++
 rtl/multi_cycle_control_alu_decoder.sv | 32 +++
 rtl/multi_cycle_control.sv | 152 +++++++++++++++
 tb/tb_multi_cycle_control.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, ALU op
// classes, opcodes and every datapath select code.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multi_cycle_control_alu_decoder.sv
// ALU decoder: maps the FSM's aluop class plus funct fields to an ALU code.
// Purely combinational, no flow control.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // only R-type (op5 set) with funct7b5 is sub; addi never is
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore FSM sequencing the multi-cycle RV32I datapath; 2-5 cycles per instruction.
// No backpressure; while rst is low all enables are held off and muxes show FETCH.
module multi_cycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic       instr_done
);

  state_t     state, state_nxt, cur;
  logic [1:0] aluop;
  logic       pc_update, branch;
  logic       mem_write_c, ir_write_c, reg_write_c, illegal_c, done_c;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  // In reset the decode sees FETCH so the muxes settle on fetch values.
  always_comb begin
    cur = rst ? state : S_FETCH;
  end

  always_comb begin
    state_nxt   = S_FETCH;
    adr_src     = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_B;
    aluop       = ALUOP_ADD;
    pc_update   = 1'b0;
    branch      = 1'b0;
    illegal_c   = 1'b0;
    done_c      = 1'b0;
    case (cur)
      S_FETCH: begin
        ir_write_c = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
        state_nxt  = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_JAL:            state_nxt = S_JAL;
          OP_BRANCH:         state_nxt = S_BEQ;
          default: begin
            illegal_c = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        state_nxt = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src   = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_A;
        aluop     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = SRCA_A;
        aluop     = ALUOP_SUB;
        branch    = 1'b1;
        done_c    = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  assign pc_write   = rst & (pc_update | (branch & zero));
  assign mem_write  = rst & mem_write_c;
  assign ir_write   = rst & ir_write_c;
  assign reg_write  = rst & reg_write_c;
  assign illegal_op = rst & illegal_c;
  assign instr_done = rst & done_c;

  always_comb begin
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: directed instruction sequences push
// hand-derived per-cycle output vectors; a negedge monitor pops and compares.
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       illegal_op, instr_done;

  int checks = 0;
  int fails  = 0;

  string       nq[$];
  logic [17:0] eq[$];

  always #5 clk = ~clk;

  multi_cycle_control dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .illegal_op  (illegal_op),
    .instr_done  (instr_done)
  );

  // Vector order: pcw adr mw irw rw rs[2] sa[2] sb[2] imm[2] ac[3] ill done
  function automatic logic [17:0] ev(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic [2:0] ac,
                                     input logic ill, input logic done);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, ac, ill, done};
  endfunction

  task automatic cyc(input string name, input logic [17:0] e);
    nq.push_back(name);
    eq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic t_reset(input logic [1:0] imm);
    cyc("reset", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0, 1'b0));
  endtask
  task automatic t_fetch(input logic [1:0] imm);
    cyc("fetch", ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0, 1'b0));
  endtask
  task automatic t_decode(input logic [1:0] imm, input logic ill);
    cyc(ill ? "decode_illegal" : "decode",
        ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, ill, 1'b0));
  endtask
  task automatic t_memadr(input logic [1:0] imm);
    cyc("memadr", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 1'b0, 1'b0));
  endtask
  task automatic t_aluwb(input logic [1:0] imm);
    cyc("aluwb", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0, 1'b1));
  endtask

  // Monitor: compares one scoreboard entry per cycle, away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (nq.size() > 0) begin
        string       n;
        logic [17:0] e, a;
        n = nq.pop_front();
        e = eq.pop_front();
        a = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
             alu_src_b, imm_src, alu_control, illegal_op, instr_done};
        checks++;
        if (a !== e) begin
          fails++;
          $display("FAIL %s @%0t: got %b expected %b", n, $time, a, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    @(posedge clk);
    #1;
    // two reset cycles with a lw opcode on the bus
    t_reset(2'b00);
    t_reset(2'b00);
    rst = 1'b1;

    // lw: 5 cycles
    t_fetch(2'b00);
    t_decode(2'b00, 1'b0);
    t_memadr(2'b00);
    cyc("lw_memread", ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
    cyc("lw_memwb",   ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1));

    // R-type sub, with zero held high to show it has no effect outside BEQ
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b1;
    t_fetch(2'b00);
    t_decode(2'b00, 1'b0);
    cyc("r_sub_execr", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0));
    t_aluwb(2'b00);

    // R-type and
    funct3 = 3'b111; funct7b5 = 1'b0; zero = 1'b0;
    t_fetch(2'b00);
    t_decode(2'b00, 1'b0);
    cyc("r_and_execr", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));
    t_aluwb(2'b00);

    // addi with funct7b5=1 must stay add since op[5]=0
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    t_fetch(2'b00);
    t_decode(2'b00, 1'b0);
    cyc("addi_execi", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));
    t_aluwb(2'b00);

    // slti, ori
    funct3 = 3'b010; funct7b5 = 1'b0;
    t_fetch(2'b00);
    t_decode(2'b00, 1'b0);
    cyc("slti_execi", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b101, 1'b0, 1'b0));
    t_aluwb(2'b00);
    funct3 = 3'b110;
    t_fetch(2'b00);
    t_decode(2'b00, 1'b0);
    cyc("ori_execi", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011, 1'b0, 1'b0));
    t_aluwb(2'b00);

    // beq taken then not taken
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    t_fetch(2'b10);
    t_decode(2'b10, 1'b0);
    cyc("beq_taken", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0, 1'b1));
    zero = 1'b0;
    t_fetch(2'b10);
    t_decode(2'b10, 1'b0);
    cyc("beq_not_taken", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0, 1'b1));

    // sw: 4 cycles
    op = 7'b0100011; funct3 = 3'b010;
    t_fetch(2'b01);
    t_decode(2'b01, 1'b0);
    t_memadr(2'b01);
    cyc("sw_memwrite", ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b1));

    // jal: 4 cycles
    op = 7'b1101111; funct3 = 3'b000;
    t_fetch(2'b11);
    t_decode(2'b11, 1'b0);
    cyc("jal", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 1'b0, 1'b0));
    t_aluwb(2'b11);

    // illegal opcode: 2 cycles then back to fetch
    op = 7'b1111111;
    t_fetch(2'b00);
    t_decode(2'b00, 1'b1);

    // sw aborted by reset in MEMWRITE
    op = 7'b0100011;
    t_fetch(2'b01);
    t_decode(2'b01, 1'b0);
    t_memadr(2'b01);
    rst = 1'b0;
    t_reset(2'b01);
    rst = 1'b1;
    t_fetch(2'b01);
    t_decode(2'b01, 1'b0);

    for (int i = 0; i < 20 && nq.size() > 0; i++) @(negedge clk);
    #1;
    if (nq.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: got %0d entries pending, expected 0", nq.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
